// File: rtl/badapple_pkg.sv
// Shared types and constants for the audio playback path.
package badapple_pkg;

    localparam int AUDIO_SAMPLE_W = 8;
    localparam logic [AUDIO_SAMPLE_W-1:0] AUDIO_MIDSCALE = 8'h80;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        PLAY  = 2'd2
    } audio_state_t;

endpackage

// File: rtl/audio_fifo_ram.sv
// Simple dual-port sample RAM with a registered read port; no reset so it maps onto block RAM.
module audio_fifo_ram
    import badapple_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [AUDIO_SAMPLE_W-1:0] wr_data,
    input  logic                      rd_en,
    input  logic [AW-1:0]             rd_addr,
    output logic [AUDIO_SAMPLE_W-1:0] rd_data
);

    logic [AUDIO_SAMPLE_W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/audio_pwm_player.sv
// Sample FIFO, IDLE/PRIME/PLAY playback control and 8-bit PWM output.
// Optional AUDIO_UNDERRUN_CNT_EN adds a saturating 16-bit underrun counter port.
module audio_pwm_player
    import badapple_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int PRIME_LEVEL = 512,
    parameter int LOW_WATER   = 512
) (
    input  logic                      CLK_40,
    input  logic                      reset_n,
    input  logic                      audio_clk_en,
    input  logic                      play_en,
    input  logic                      flush,
    input  logic                      wr_en,
    input  logic [AUDIO_SAMPLE_W-1:0] wr_data,
    output logic                      full,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      audio_data_ready,
    output logic [AUDIO_SAMPLE_W-1:0] sample_out,
    output logic                      underrun,
    output logic                      pwm_out
`ifdef AUDIO_UNDERRUN_CNT_EN
    ,
    output logic [15:0]               underrun_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [LW-1:0]             wr_ptr_r, rd_ptr_r, level_s;
    logic                      full_s, empty_s, wr_ok_s, tick_play_s, pop_s, tick_empty_s;
    audio_state_t              state_r, state_nxt_s;
    logic [AW-1:0]             rd_addr_r;
    logic                      pop_d1_r, pop_d2_r;
    logic [AUDIO_SAMPLE_W-1:0] ram_rd_data_s;
    logic                      underrun_pend_r, underrun_r, data_ready_r;
    logic [AUDIO_SAMPLE_W-1:0] sample_out_r, pwm_cnt_r, pwm_sample_r;
    logic                      pwm_out_r;

    assign level_s      = wr_ptr_r - rd_ptr_r;
    assign empty_s      = (wr_ptr_r == rd_ptr_r);
    assign full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign wr_ok_s      = wr_en && !full_s && !flush;
    assign tick_play_s  = (state_r == PLAY) && audio_clk_en && play_en && !flush;
    assign pop_s        = tick_play_s && !empty_s;
    assign tick_empty_s = tick_play_s && empty_s;

    // FIFO pointers; flush wins over any write or pop in the same cycle
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)   rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Pop pipeline: address captured at the tick, RAM read one edge later, sample the edge after
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            rd_addr_r <= '0;
            pop_d1_r  <= 1'b0;
            pop_d2_r  <= 1'b0;
        end else begin
            if (pop_s) rd_addr_r <= rd_ptr_r[AW-1:0];
            pop_d1_r <= pop_s;
            pop_d2_r <= pop_d1_r;
        end
    end

    audio_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk     (CLK_40),
        .wr_en   (wr_ok_s),
        .wr_addr (wr_ptr_r[AW-1:0]),
        .wr_data (wr_data),
        .rd_en   (pop_d1_r),
        .rd_addr (rd_addr_r),
        .rd_data (ram_rd_data_s)
    );

    // Playback state register
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) state_r <= IDLE;
        else          state_r <= state_nxt_s;
    end

    // Next-state logic; dropping play_en always returns to IDLE, contents kept
    always_comb begin
        state_nxt_s = state_r;
        if (!play_en) begin
            state_nxt_s = IDLE;
        end else if (flush) begin
            state_nxt_s = PRIME;
        end else begin
            case (state_r)
                IDLE:    state_nxt_s = PRIME;
                PRIME:   state_nxt_s = (level_s >= LW'(PRIME_LEVEL)) ? PLAY : PRIME;
                PLAY:    state_nxt_s = tick_empty_s ? PRIME : PLAY;
                default: state_nxt_s = IDLE;
            endcase
        end
    end

    // Sample output, underrun pulse (delayed one edge after the empty tick) and refill request
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            sample_out_r    <= AUDIO_MIDSCALE;
            underrun_pend_r <= 1'b0;
            underrun_r      <= 1'b0;
            data_ready_r    <= 1'b0;
        end else begin
            if (state_r == IDLE) sample_out_r <= AUDIO_MIDSCALE;
            else if (pop_d2_r)   sample_out_r <= ram_rd_data_s;
            underrun_pend_r <= tick_empty_s;
            underrun_r      <= underrun_pend_r;
            data_ready_r    <= flush ? 1'b0 : (level_s < LW'(LOW_WATER));
        end
    end

    // PWM carrier; duty only reloads at the counter wrap
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            pwm_cnt_r    <= 8'h00;
            pwm_sample_r <= AUDIO_MIDSCALE;
            pwm_out_r    <= 1'b0;
        end else begin
            pwm_cnt_r <= pwm_cnt_r + 8'd1;
            if (pwm_cnt_r == 8'hFF) pwm_sample_r <= sample_out_r;
            pwm_out_r <= (pwm_cnt_r < pwm_sample_r);
        end
    end

`ifdef AUDIO_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_r;

    // Saturating underrun counter, cleared only by reset
    always_ff @(posedge CLK_40 or negedge reset_n) begin
        if (!reset_n) begin
            underrun_cnt_r <= 16'h0000;
        end else if (underrun_r && (underrun_cnt_r != 16'hFFFF)) begin
            underrun_cnt_r <= underrun_cnt_r + 16'd1;
        end
    end

    assign underrun_count = underrun_cnt_r;
`endif

    assign full             = full_s;
    assign level            = level_s;
    assign audio_data_ready = data_ready_r;
    assign sample_out       = sample_out_r;
    assign underrun         = underrun_r;
    assign pwm_out          = pwm_out_r;

endmodule
